match_copy_decoder: RTL and testbench
=====================================

// Module: match_copy_decoder
// PURPOSE
//  Decompression-side counterpart of the single-cycle pattern search. Consumes literal and match tokens.
//  A match token is (patternIndex, length), as produced by the search.
//  Expands each token into the byte stream and appends every emitted byte to a circular history buffer.
//  Output is one byte per cycle on a ready/valid port, feeding the downstream decompressed-data sink.
// PARAMETERS
//  HISTORY_DEPTH  4096  history bytes; must be a power of two and equal 2**INDEX_WIDTH
//  INDEX_WIDTH    12    width of tokenIndex, wrPtr and srcPtr
//  LENGTH_WIDTH   3     width of tokenLength; maximum match is 7 bytes
//  DATA_WIDTH     8     byte width
// PORTS
//  clock          in   1   single clock; all state updates on the rising edge
//  reset          in   1   asynchronous, active-low; 0 = in reset
//  tokenReady     out  1   decoder can accept a token this cycle
//  tokenValid     in   1   token present
//  tokenIsMatch   in   1   1 = match token; 0 = literal token
//  tokenLiteral   in   8   literal byte; used only when tokenIsMatch=0
//  tokenIndex     in   12  absolute history address of the first match byte
//  tokenLength    in   3   match length in bytes, 0..7
//  outReady       in   1   sink accepts a byte
//  outValid       out  1   outData holds a byte
//  outData        out  8   decompressed byte
//  busy           out  1   1 while in the COPY state
//  wrPtr          out  12  next history write address; equals bytes emitted mod HISTORY_DEPTH
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state=IDLE, outValid=0, outData=0, wrPtr=0, srcPtr=0, remaining=0, busy=0.
//   - History contents are not reset. An in-flight copy is abandoned and the held output byte is dropped.
//  Output slot:
//   - free = !outValid || outReady.
//   - A "push" loads outData, sets outValid=1 and writes history[wrPtr] with the same byte.
//     It also advances wrPtr = wrPtr+1 mod HISTORY_DEPTH, wrapping 4095->0.
//   - When free and no push occurs, outValid goes to 0.
//   - outData stays stable while outValid=1 and outReady=0.
//  IDLE:
//   - tokenReady = free.
//   - Accept on tokenValid && tokenReady.
//   - Literal token: push tokenLiteral in the same cycle. Latency is 1, so the byte is valid the next cycle.
//   - Match token with tokenLength=0: consumed, no push, remain in IDLE.
//   - Match token with tokenLength>0: srcPtr<=tokenIndex, remaining<=tokenLength, go to COPY. No push in that cycle.
//  COPY:
//   - tokenReady=0 and busy=1.
//   - Each cycle the slot is free: push history[srcPtr]; srcPtr++ with modulo wrap; remaining--.
//   - When remaining reaches 0 on a push, return to IDLE. The next token can be accepted the cycle after.
//   - Slot not free: hold srcPtr and remaining (stall), no push.
//   - First match byte is valid 2 cycles after token accept. Then 1 byte per cycle with outReady=1.
//  Arithmetic and overlap:
//   - History is read combinationally; a push writes at the clock edge.
//   - A byte pushed in cycle t is readable in cycle t+1. This makes overlapping copies work:
//     with srcPtr=wrPtr-1, a length-n copy repeats the last byte n times.
//   - With tokenIndex==wrPtr at accept, the copy reads data written HISTORY_DEPTH bytes earlier (stale data).
//     This is legal and not flagged.
//   - Address arithmetic is INDEX_WIDTH bits and wraps; no range checks.
//  Simultaneous events:
//   - The output byte can be taken by outReady and a new byte pushed in the same cycle, giving full throughput.
//   - tokenValid may assert during COPY; the token is held upstream because tokenReady=0.
//  Throughput: 1 byte/cycle sustained, plus 1 bubble cycle per match token.
// TESTING
//  1. Literals 0x41,0x42,0x43 back-to-back, outReady=1 -> outData 41,42,43 on consecutive cycles.
//     First byte valid the cycle after accept; wrPtr=3.
//  2. After test 1, match(index=0,len=3) -> 41,42,43; first byte valid 2 cycles after accept;
//     tokenReady=0 during COPY; wrPtr=6.
//  3. Literal 0x5A at wrPtr=6, then match(index=6,len=7) -> eight 0x5A bytes in total; wrPtr=14.
//  4. Backpressure: outReady toggling 1,0,0,1 during a len-4 copy -> no byte lost or duplicated;
//     outData stable while stalled.
//  5. Wrap: drive 4094 literals (i mod 256), then literal 0xEE, literal 0xFF (wrPtr 4094->4095->0),
//     then match(index=4094,len=4) -> EE,FF,00,01; wrPtr=4.
//  6. Reset asserted mid-copy (2 of 7 bytes emitted) -> same cycle outValid=0, busy=0, wrPtr=0.
//     After release, literal 0x11 -> 0x11 appears.
//  7. match(len=0) -> tokenReady stays 1, no output, wrPtr unchanged.

Source files
------------

// File: rtl/match_copy_decoder.sv
// Token expander for the match/literal stream: literals pass straight through, matches copy
// from a circular history, and every emitted byte is appended to that history.
module match_copy_decoder #(
  parameter int HISTORY_DEPTH = 4096,
  parameter int INDEX_WIDTH   = 12,
  parameter int LENGTH_WIDTH  = 3,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    tokenReady,
  input  logic                    tokenValid,
  input  logic                    tokenIsMatch,
  input  logic [DATA_WIDTH-1:0]   tokenLiteral,
  input  logic [INDEX_WIDTH-1:0]  tokenIndex,
  input  logic [LENGTH_WIDTH-1:0] tokenLength,
  input  logic                    outReady,
  output logic                    outValid,
  output logic [DATA_WIDTH-1:0]   outData,
  output logic                    busy,
  output logic [INDEX_WIDTH-1:0]  wrPtr
);
  typedef enum logic {IDLE, COPY} state_e;

  state_e                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [INDEX_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [INDEX_WIDTH-1:0]  src_ptr_q, src_ptr_d;
  logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   hist_q [HISTORY_DEPTH];

  logic                    free, accept, push;
  logic [DATA_WIDTH-1:0]   push_data;

  assign free   = !out_valid_q || outReady;
  assign accept = tokenValid && tokenReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && tokenIsMatch && tokenLength != '0) state_d = COPY;
      COPY:    if (free && rem_q == LENGTH_WIDTH'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tokenReady = (state_q == IDLE) && free;
    busy       = (state_q == COPY);
  end

  always_comb begin
    push        = 1'b0;
    push_data   = hist_q[src_ptr_q];
    src_ptr_d   = src_ptr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_ptr_d    = wr_ptr_q;
    if (state_q == IDLE) begin
      if (accept && !tokenIsMatch) begin
        push      = 1'b1;
        push_data = tokenLiteral;
      end else if (accept && tokenLength != '0) begin
        src_ptr_d = tokenIndex;
        rem_d     = tokenLength;
      end
    end else if (free) begin
      push      = 1'b1;
      src_ptr_d = src_ptr_q + INDEX_WIDTH'(1);
      rem_d     = rem_q - LENGTH_WIDTH'(1);
    end
    if (push) begin
      out_valid_d = 1'b1;
      out_data_d  = push_data;
      wr_ptr_d    = wr_ptr_q + INDEX_WIDTH'(1);
    end else if (free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      src_ptr_q   <= '0;
      rem_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      src_ptr_q   <= src_ptr_d;
      rem_q       <= rem_d;
    end
  end

  // History is never cleared; a write landing during reset would corrupt it, so gate it off.
  always_ff @(posedge clock) begin
    if (push && reset) hist_q[wr_ptr_q] <= push_data;
  end

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign wrPtr    = wr_ptr_q;
endmodule

// File: tb/tb_match_copy_decoder.sv
// Directed + randomized bench: a byte-stream/history model expands tokens, a negedge monitor
// checks every byte taken and that held bytes stay stable under backpressure.
module tb_match_copy_decoder;
  logic        clock, reset;
  logic        tokenReady, tokenValid, tokenIsMatch;
  logic [7:0]  tokenLiteral;
  logic [11:0] tokenIndex;
  logic [2:0]  tokenLength;
  logic        outReady, outValid, busy;
  logic [7:0]  outData;
  logic [11:0] wrPtr;

  match_copy_decoder dut (
    .clock(clock), .reset(reset), .tokenReady(tokenReady), .tokenValid(tokenValid),
    .tokenIsMatch(tokenIsMatch), .tokenLiteral(tokenLiteral), .tokenIndex(tokenIndex),
    .tokenLength(tokenLength), .outReady(outReady), .outValid(outValid), .outData(outData),
    .busy(busy), .wrPtr(wrPtr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         tests = 0, fails = 0, n_taken = 0, wr_m = 0;
  logic [7:0] hist_m [4096];
  logic [7:0] exp_q [$];
  bit         rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    tests++;
    assert (got === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // Reference: expand a token into bytes, appending each to the history as it is produced.
  task automatic model_accept(input bit m, input logic [7:0] lit, input int idx, input int len);
    logic [7:0] b;
    if (!m) begin
      exp_q.push_back(lit); hist_m[wr_m] = lit; wr_m = (wr_m + 1) % 4096;
    end else begin
      for (int k = 0; k < len; k++) begin
        b = hist_m[(idx + k) % 4096];
        exp_q.push_back(b); hist_m[wr_m] = b; wr_m = (wr_m + 1) % 4096;
      end
    end
  endtask

  bit         stall_prev = 1'b0;
  logic [7:0] held;
  always @(negedge clock) begin
    if (reset) begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, outValid}, 32'd1);
        chk("stall_data", {24'd0, outData}, {24'd0, held});
      end
      if (outValid && outReady) begin
        n_taken++;
        if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, outData}, 32'hFFFF_FFFF);
        else chk("stream", {24'd0, outData}, {24'd0, exp_q.pop_front()});
      end
      stall_prev = outValid && !outReady;
      held = outData;
    end else stall_prev = 1'b0;
  end

  always @(posedge clock) if (rand_rdy) begin
    #1; if (rand_rdy) outReady = ($urandom % 4) != 0;
  end

  task automatic cycle();
    @(posedge clock); #1;
  endtask

  task automatic send(input bit m, input logic [7:0] lit, input int idx, input int len);
    int n = 0;
    tokenValid = 1'b1; tokenIsMatch = m; tokenLiteral = lit;
    tokenIndex = 12'(idx); tokenLength = 3'(len);
    @(negedge clock);
    while (!tokenReady && n < 200) begin @(negedge clock); n++; end
    chk("accept", {31'd0, tokenReady}, 32'd1);
    if (tokenReady) model_accept(m, lit, idx, len);
    @(posedge clock); #1;
    tokenValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    outReady = 1'b1;
    @(negedge clock);
    while (!(exp_q.size() == 0 && !outValid && !busy) && n < 300) begin
      outReady = 1'b1; @(negedge clock); n++;
    end
    chk("drain_queue", exp_q.size(), 32'd0);
    chk("drain_wrptr", {20'd0, wrPtr}, 32'(wr_m));
    @(posedge clock); #1;
  endtask

  initial begin
    int t0;
    reset = 1'b0; tokenValid = 1'b0; tokenIsMatch = 1'b0; tokenLiteral = '0;
    tokenIndex = '0; tokenLength = '0; outReady = 1'b1;
    #2;
    chk("rst_valid", {31'd0, outValid}, 32'd0);
    chk("rst_data", {24'd0, outData}, 32'd0);
    chk("rst_wrptr", {20'd0, wrPtr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tready", {31'd0, tokenReady}, 32'd1);
    cycle(); reset = 1'b1; cycle();

    // 1: back-to-back literals
    send(0, 8'h41, 0, 0);
    chk("t1_lat_valid", {31'd0, outValid}, 32'd1);
    chk("t1_lat_data", {24'd0, outData}, 32'h41);
    send(0, 8'h42, 0, 0);
    send(0, 8'h43, 0, 0);
    chk("t1_wrptr", {20'd0, wrPtr}, 32'd3);

    // 2: match copy latency
    send(1, 8'h00, 0, 3);
    chk("t2_tready_copy", {31'd0, tokenReady}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_no_byte_yet", {31'd0, outValid}, 32'd0);
    cycle();
    chk("t2_first_valid", {31'd0, outValid}, 32'd1);
    chk("t2_first_data", {24'd0, outData}, 32'h41);
    drain();
    chk("t2_wrptr", {20'd0, wrPtr}, 32'd6);

    // 3: overlapping copy repeats last byte
    t0 = n_taken;
    send(0, 8'h5A, 0, 0);
    send(1, 8'h00, 6, 7);
    drain();
    chk("t3_count", n_taken - t0, 32'd8);
    chk("t3_wrptr", {20'd0, wrPtr}, 32'd14);

    // 4: backpressure 1,0,0,1 during a length-4 copy
    t0 = n_taken;
    send(1, 8'h00, 0, 4);
    cycle();
    outReady = 1'b1; cycle();
    outReady = 1'b0; cycle();
    chk("t4_busy_stall", {31'd0, busy}, 32'd1);
    cycle();
    outReady = 1'b1;
    drain();
    chk("t4_count", n_taken - t0, 32'd4);

    // 5: pointer wrap
    reset = 1'b0; #1;
    chk("t5_rst_wrptr", {20'd0, wrPtr}, 32'd0);
    exp_q.delete(); wr_m = 0;
    cycle(); reset = 1'b1; cycle();
    for (int i = 0; i < 4094; i++) send(0, 8'(i % 256), 0, 0);
    chk("t5_wrptr_4094", {20'd0, wrPtr}, 32'd4094);
    send(0, 8'hEE, 0, 0);
    chk("t5_wrptr_4095", {20'd0, wrPtr}, 32'd4095);
    send(0, 8'hFF, 0, 0);
    chk("t5_wrptr_0", {20'd0, wrPtr}, 32'd0);
    send(1, 8'h00, 4094, 4);
    drain();
    chk("t5_wrptr", {20'd0, wrPtr}, 32'd4);

    // 7: zero-length match
    send(1, 8'h00, 100, 0);
    chk("t7_tready", {31'd0, tokenReady}, 32'd1);
    chk("t7_no_out", {31'd0, outValid}, 32'd0);
    chk("t7_wrptr", {20'd0, wrPtr}, 32'd4);

    // randomized tokens with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 2 == 0) send(0, 8'($urandom), 0, 0);
      else send(1, 8'h00, ((wr_m - int'($urandom_range(4096, 1))) % 4096 + 4096) % 4096,
                int'($urandom_range(7, 0)));
    end
    rand_rdy = 1'b0;
    drain();

    // 6: reset mid-copy
    send(1, 8'h00, (wr_m + 4086) % 4096, 7);
    cycle(); cycle();
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0; #1;
    chk("t6_valid", {31'd0, outValid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_wrptr", {20'd0, wrPtr}, 32'd0);
    exp_q.delete(); wr_m = 0;
    cycle(); reset = 1'b1; cycle();
    send(0, 8'h11, 0, 0);
    chk("t6_lit_valid", {31'd0, outValid}, 32'd1);
    chk("t6_lit_data", {24'd0, outData}, 32'h11);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
